spi_arb_ctrl: RTL and testbench
===============================

SPI_ARB_CTRL -- requirements
Module: spi_arb_ctrl

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 2: clk cycles per seq_clk half-period; legal range 1..15.
REQ-002 SHALL provide port clk, input, 1: the single clock; all logic on its rising edge.
REQ-003 SHALL provide port s_reset, input, 1: reset, synchronous and active-low.
REQ-004 SHALL provide port req, input, 2: per-requester transfer request, level, held until done.
REQ-005 SHALL provide ports wdata0 and wdata1, input, 8 each: transmit byte for requester 0 and requester 1.
REQ-006 SHALL provide port gnt, output, 2: one-cycle grant pulse per requester.
REQ-007 SHALL provide port done, output, 2: one-cycle completion pulse per requester.
REQ-008 SHALL provide port rdata, output, 8: received byte, valid only while done is high.
REQ-009 SHALL provide port busy, output, 1: high from the grant cycle through the done cycle inclusive.
REQ-010 SHALL provide port cs_n, output, 2: active-low chip select, bit i for requester i's slave.
REQ-011 SHALL provide port seq_clk, output, 1: SPI serial clock, idle low.
REQ-012 SHALL provide port mosi, output, 1: serial data out.
REQ-013 SHALL provide port miso, input, 1: serial data in.

Function
REQ-014 SHALL implement states IDLE, XFER and DONE, with every output registered.
REQ-015 IDLE: on any req bit high, SHALL select a winner (REQ-022), pulse gnt[winner], latch wdata[winner] into the shift register, drive cs_n[winner] low and mosi to bit 0, clear the divider and bit counter, and enter XFER.
REQ-016 XFER: the divider SHALL count 0..CLK_DIV-1 and toggle seq_clk on terminal count; first rise at CLK_DIV cycles after the grant edge.
REQ-017 On each seq_clk rise, SHALL sample miso into rx[bit_cnt]; ordering is LSB first.
REQ-018 On each seq_clk fall with bit_cnt<7, SHALL increment bit_cnt and drive mosi to data[bit_cnt+1].
REQ-019 On the seq_clk fall with bit_cnt=7, SHALL hold seq_clk low and enter DONE; the last fall occurs 16*CLK_DIV cycles after grant.
REQ-020 DONE lasts one cycle: SHALL pulse done[owner], present rx on rdata, drive all cs_n high and mosi low, then return to IDLE.
REQ-021 Every transfer SHALL span exactly 16*CLK_DIV+1 cycles from grant to done, with a minimum of one IDLE cycle between consecutive transfers.
REQ-022 Arbitration: only one req high grants that requester; both high is resolved per REQ-031/REQ-032.
REQ-023 A req deasserted before its grant SHALL be withdrawn; req changes after grant SHALL NOT affect the transfer in progress.
REQ-024 wdata changes after the grant cycle SHALL NOT affect transmitted bits.
REQ-025 At most one cs_n bit SHALL be low at any time, and none outside XFER.
REQ-026 rdata SHALL hold its last value outside done cycles.

Reset
REQ-027 With s_reset low at a rising clk edge: state=IDLE, cs_n=2'b11, seq_clk=0, mosi=0, gnt=0, done=0, busy=0, rdata=0, counters=0, round-robin pointer=requester 0 preferred.
REQ-028 Reset mid-transfer SHALL abort it with no done pulse; cs_n is high from the next edge.
REQ-029 The first grant SHALL be possible on the first edge with s_reset high.

Configuration
REQ-030 Macro SPI_ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-031 Defined: when both requesters request, grant the one not served last; the pointer updates at each grant.
REQ-032 Undefined: fixed priority, requester 0 always wins on a tie; no pointer logic is present.

Verification
REQ-033 Single transfer: CLK_DIV=2, req=01, wdata0=8'hA5, slave returns 8'h3C -> mosi sequence 1,0,1,0,0,1,0,1; done[0] at grant+33; rdata=8'h3C.
REQ-034 Simultaneous requests: req=11 held for three transfers -> with RR_EN, grant order 0,1,0; without it, grant order 0,0,0.
REQ-035 Reset mid-transfer: s_reset low at grant+10 -> no done; next cycle cs_n=11, seq_clk=0, busy=0.
REQ-036 Boundary divider: CLK_DIV=1, wdata1=8'hFF, req=10 -> eight seq_clk pulses, cs_n[1] low for 17 cycles, done[1] at grant+17.
REQ-037 Withdrawn request: req0 pulsed for one cycle while busy with requester 1 -> no gnt[0] after requester 1's done.
REQ-038 Data stability: wdata0 changed to 8'h00 at grant+1 -> transmitted byte equals the value latched at grant.

Source files
------------

// File: rtl/spi_arb_ctrl.sv
// Two-requester SPI master: arbitrates req[1:0] and runs one 8-bit LSB-first transfer per grant.
// Define SPI_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise requester 0 wins ties.
module spi_arb_ctrl #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       s_reset,
    input  logic [1:0] req,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic [7:0] rdata,
    output logic       busy,
    output logic [1:0] cs_n,
    output logic       seq_clk,
    output logic       mosi,
    input  logic       miso
);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } state_t;

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    state_t     state_q, state_d;
    logic [3:0] div_q, div_d;
    logic [2:0] bit_q, bit_d;
    logic [2:0] nxt_bit;
    logic [7:0] data_q, data_d;
    logic [7:0] rx_q, rx_d;
    logic       owner_q, owner_d;
    logic       winner;
    logic [7:0] win_data;

    logic [1:0] gnt_d, done_d, cs_n_d;
    logic [7:0] rdata_d;
    logic       busy_d, seq_d, mosi_d;

`ifdef SPI_ARB_ROUND_ROBIN_EN
    logic pref_q, pref_d;

    always_comb begin
        if (req == 2'b11) winner = pref_q;
        else              winner = ~req[0];
    end
`else
    always_comb winner = ~req[0];
`endif

    assign win_data = winner ? wdata1 : wdata0;
    assign nxt_bit  = bit_q + 3'd1;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        data_d  = data_q;
        rx_d    = rx_q;
        owner_d = owner_q;
        gnt_d   = 2'b00;
        done_d  = 2'b00;
        rdata_d = rdata;
        cs_n_d  = cs_n;
        seq_d   = seq_clk;
        mosi_d  = mosi;
`ifdef SPI_ARB_ROUND_ROBIN_EN
        pref_d  = pref_q;
`endif
        unique case (state_q)
            IDLE: begin
                // the done cycle doubles as the mandatory idle gap
                if (|req && !(|done)) begin
                    gnt_d   = winner ? 2'b10 : 2'b01;
                    cs_n_d  = winner ? 2'b01 : 2'b10;
                    owner_d = winner;
                    data_d  = win_data;
                    mosi_d  = win_data[0];
                    div_d   = 4'd0;
                    bit_d   = 3'd0;
                    seq_d   = 1'b0;
                    state_d = XFER;
`ifdef SPI_ARB_ROUND_ROBIN_EN
                    pref_d  = ~winner;
`endif
                end
            end
            XFER: begin
                if (div_q == DIV_LAST) begin
                    div_d = 4'd0;
                    if (!seq_clk) begin
                        seq_d       = 1'b1;
                        rx_d[bit_q] = miso;
                    end else begin
                        seq_d = 1'b0;
                        if (bit_q != 3'd7) begin
                            bit_d  = nxt_bit;
                            mosi_d = data_q[nxt_bit];
                        end else begin
                            state_d = DONE;
                        end
                    end
                end else begin
                    div_d = div_q + 4'd1;
                end
            end
            DONE: begin
                done_d  = owner_q ? 2'b10 : 2'b01;
                rdata_d = rx_q;
                cs_n_d  = 2'b11;
                mosi_d  = 1'b0;
                seq_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE) || (|done_d);
    end

    always_ff @(posedge clk) begin
        if (!s_reset) begin
            state_q <= IDLE;
            div_q   <= 4'd0;
            bit_q   <= 3'd0;
            data_q  <= 8'd0;
            rx_q    <= 8'd0;
            owner_q <= 1'b0;
            gnt     <= 2'b00;
            done    <= 2'b00;
            rdata   <= 8'd0;
            busy    <= 1'b0;
            cs_n    <= 2'b11;
            seq_clk <= 1'b0;
            mosi    <= 1'b0;
`ifdef SPI_ARB_ROUND_ROBIN_EN
            pref_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            rx_q    <= rx_d;
            owner_q <= owner_d;
            gnt     <= gnt_d;
            done    <= done_d;
            rdata   <= rdata_d;
            busy    <= busy_d;
            cs_n    <= cs_n_d;
            seq_clk <= seq_d;
            mosi    <= mosi_d;
`ifdef SPI_ARB_ROUND_ROBIN_EN
            pref_q  <= pref_d;
`endif
        end
    end

endmodule

// File: tb/tb_spi_arb_ctrl.sv
// Bench for spi_arb_ctrl: CLK_DIV=2 and CLK_DIV=1 instances, slave models, scoreboard.
// Tie expectations follow SPI_ARB_ROUND_ROBIN_EN when defined.
module tb_spi_arb_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       s_reset = 1'b0;
    logic [1:0] req_a = 2'b00, req_b = 2'b00;
    logic [7:0] wdata0 = 8'h00, wdata1 = 8'h00;
    logic       miso_a = 1'b0, miso_b = 1'b0;

    logic [1:0] gnt_a, done_a, cs_n_a, gnt_b, done_b, cs_n_b;
    logic [7:0] rdata_a, rdata_b;
    logic       busy_a, seq_a, mosi_a, busy_b, seq_b, mosi_b;

    spi_arb_ctrl #(.CLK_DIV(2)) dut (
        .clk(clk), .s_reset(s_reset), .req(req_a),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt_a), .done(done_a), .rdata(rdata_a), .busy(busy_a),
        .cs_n(cs_n_a), .seq_clk(seq_a), .mosi(mosi_a), .miso(miso_a)
    );

    spi_arb_ctrl #(.CLK_DIV(1)) dut1 (
        .clk(clk), .s_reset(s_reset), .req(req_b),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt_b), .done(done_b), .rdata(rdata_b), .busy(busy_b),
        .cs_n(cs_n_b), .seq_clk(seq_b), .mosi(mosi_b), .miso(miso_b)
    );

    // slave models: present bit k after the k-th seq_clk fall
    logic [7:0] slave_byte = 8'h00;
    logic [3:0] idx_a = '0, idx_b = '0;
    logic       pa = 1'b0, pb = 1'b0;

    always @(negedge clk) begin
        if (cs_n_a == 2'b11) idx_a = '0;
        else if (pa && !seq_a) idx_a = idx_a + 4'd1;
        pa = seq_a;
        miso_a = slave_byte[idx_a[2:0]];
        if (cs_n_b == 2'b11) idx_b = '0;
        else if (pb && !seq_b) idx_b = idx_b + 4'd1;
        pb = seq_b;
        miso_b = slave_byte[idx_b[2:0]];
    end

    logic       sel = 1'b0;
    logic [1:0] gnt_m, done_m, cs_n_m;
    logic [7:0] rdata_m;
    logic       busy_m, seq_m, mosi_m;

    always_comb begin
        gnt_m   = sel ? gnt_b   : gnt_a;
        done_m  = sel ? done_b  : done_a;
        cs_n_m  = sel ? cs_n_b  : cs_n_a;
        rdata_m = sel ? rdata_b : rdata_a;
        busy_m  = sel ? busy_b  : busy_a;
        seq_m   = sel ? seq_b   : seq_a;
        mosi_m  = sel ? mosi_b  : mosi_a;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       s;
        logic [1:0] r;
        logic [7:0] w0;
        logic [7:0] w1;
        logic [7:0] slv;
        logic       chg;
        logic       own;
    } vec_t;

    typedef struct {
        logic       own;
        logic [7:0] rd;
        logic [7:0] mo;
        int         lat;
    } exp_t;

    exp_t sb[$];

    task automatic set_req(input logic s, input logic [1:0] r);
        if (s) req_b = r;
        else   req_a = r;
    endtask

    task automatic run_xfer(input logic s, input logic [1:0] r, input logic [7:0] w0,
                            input logic [7:0] w1, input logic [7:0] slv,
                            input logic chg, input logic hold, input logic own);
        exp_t e, g;
        int n, rises, low;
        logic [7:0] mo;
        logic pseq, got, both_low;
        sel = s;
        wdata0 = w0;
        wdata1 = w1;
        slave_byte = slv;
        e.own = own;
        e.rd  = slv;
        e.mo  = own ? w1 : w0;
        e.lat = s ? 17 : 33;
        sb.push_back(e);
        set_req(s, r);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = |gnt_m;
        end
        chk("gnt_seen", 32'(got), 1);
        chk("gnt_owner", 32'(gnt_m), own ? 2'b10 : 2'b01);
        chk("busy_at_gnt", 32'(busy_m), 1);
        if (chg) begin
            wdata0 = 8'h00;
            wdata1 = 8'h00;
        end
        rises = 0;
        low = (cs_n_m[own] == 1'b0) ? 1 : 0;
        mo = 8'h00;
        pseq = seq_m;
        both_low = 1'b0;
        n = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            if (seq_m && !pseq) begin
                if (rises < 8) mo[rises] = mosi_m;
                rises++;
            end
            pseq = seq_m;
            if (cs_n_m[own] == 1'b0) low++;
            if (cs_n_m == 2'b00) both_low = 1'b1;
            got = |done_m;
        end
        if (!hold) set_req(s, 2'b00);
        g = sb.pop_front();
        chk("done_seen", 32'(got), 1);
        chk("latency", n, g.lat);
        chk("done_owner", 32'(done_m), g.own ? 2'b10 : 2'b01);
        chk("rdata", 32'(rdata_m), 32'(g.rd));
        chk("mosi_byte", 32'(mo), 32'(g.mo));
        chk("seq_rises", rises, 8);
        chk("cs_low_cycles", low, g.lat);
        chk("cs_one_hot", 32'(both_low), 0);
        chk("busy_at_done", 32'(busy_m), 1);
        chk("cs_high_at_done", 32'(cs_n_m), 2'b11);
        @(negedge clk);
        chk("busy_after", 32'(busy_m), 0);
        chk("rdata_hold", 32'(rdata_m), 32'(g.rd));
        chk("mosi_idle", 32'(mosi_m), 0);
    endtask

    task automatic do_reset();
        s_reset = 1'b0;
        req_a = 2'b00;
        req_b = 2'b00;
        repeat (2) @(negedge clk);
        s_reset = 1'b1;
    endtask

    vec_t vecs[8];
    logic rr;
    int   gcnt;
    logic got;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 2'b01, 8'hA5, 8'h00, 8'h3C, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 2'b10, 8'h11, 8'h5A, 8'hC3, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 2'b01, 8'h00, 8'h22, 8'hFF, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 2'b10, 8'h33, 8'hFF, 8'h00, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 2'b11, 8'h81, 8'h7E, 8'h96, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 2'b01, 8'hC6, 8'h00, 8'h5D, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 2'b10, 8'h00, 8'hFF, 8'hA7, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 2'b01, 8'h3E, 8'h00, 8'hE1, 1'b0, 1'b0};
`ifdef SPI_ARB_ROUND_ROBIN_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif

        repeat (2) @(negedge clk);
        chk("rst_cs_n", 32'(cs_n_a), 2'b11);
        chk("rst_seq", 32'(seq_a), 0);
        chk("rst_mosi", 32'(mosi_a), 0);
        chk("rst_gnt", 32'(gnt_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_rdata", 32'(rdata_a), 0);
        chk("rst_cs_n_b", 32'(cs_n_b), 2'b11);
        chk("rst_busy_b", 32'(busy_b), 0);

        req_a = 2'b01;
        s_reset = 1'b1;
        @(negedge clk);
        chk("first_grant", 32'(gnt_a), 2'b01);
        do_reset();

        foreach (vecs[i])
            run_xfer(vecs[i].s, vecs[i].r, vecs[i].w0, vecs[i].w1,
                     vecs[i].slv, vecs[i].chg, 1'b0, vecs[i].own);

        do_reset();
        run_xfer(1'b0, 2'b11, 8'h55, 8'hAA, 8'h0F, 1'b0, 1'b1, 1'b0);
        run_xfer(1'b0, 2'b11, 8'h55, 8'hAA, 8'hF0, 1'b0, 1'b1, rr);
        run_xfer(1'b0, 2'b11, 8'h55, 8'hAA, 8'h69, 1'b0, 1'b0, 1'b0);

        sel = 1'b0;
        wdata0 = 8'h99;
        req_a = 2'b01;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = |gnt_a;
        end
        chk("abort_gnt_seen", 32'(got), 1);
        repeat (9) @(negedge clk);
        s_reset = 1'b0;
        @(negedge clk);
        chk("abort_cs_n", 32'(cs_n_a), 2'b11);
        chk("abort_seq", 32'(seq_a), 0);
        chk("abort_busy", 32'(busy_a), 0);
        chk("abort_done", 32'(done_a), 0);
        s_reset = 1'b1;
        @(negedge clk);
        chk("regrant_after_reset", 32'(gnt_a), 2'b01);
        do_reset();

        req_a = 2'b10;
        wdata1 = 8'h4B;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = |gnt_a;
        end
        chk("wd_gnt1", 32'(gnt_a), 2'b10);
        repeat (4) @(negedge clk);
        req_a = 2'b11;
        @(negedge clk);
        req_a = 2'b10;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            got = |done_a;
        end
        chk("wd_done1", 32'(done_a), 2'b10);
        req_a = 2'b00;
        gcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (gnt_a[0]) gcnt++;
        end
        chk("wd_no_gnt0", gcnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
